// File: rtl/hid_key_events_pkg.sv
// Shared types and constants for the HID keyboard event path.
// Event word layout is {make, code[7:0], mods[7:0]}.
package hid_key_events_pkg;
  localparam logic [1:0] USB_TYP_NONE    = 2'd0;
  localparam logic [1:0] USB_TYP_KBD     = 2'd1;
  localparam logic [1:0] USB_TYP_MOUSE   = 2'd2;
  localparam logic [1:0] USB_TYP_GAMEPAD = 2'd3;

  localparam logic [7:0] HID_ROLLOVER = 8'h01;
  localparam logic [7:0] HID_MOD_BASE = 8'hE0;
  localparam int         NKEYS        = 4;
  localparam int         EV_W         = 17;

  typedef logic [NKEYS-1:0][7:0] keys_t;

  typedef struct packed {
    logic       make;
    logic [7:0] code;
    logic [7:0] mods;
  } hid_ev_t;

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_MOD, S_MAK, S_COMMIT} scan_st_t;

  // True when k appears in set[0..lim-1].
  function automatic logic key_hit(input logic [7:0] k, input keys_t set, input int lim);
    key_hit = 1'b0;
    for (int j = 0; j < NKEYS; j++)
      if (j < lim && set[j] == k) key_hit = 1'b1;
  endfunction
endpackage

// File: rtl/hid_key_events_fifo.sv
// Synchronous FIFO with registered head, occupancy count and a drop strobe
// for pushes that could not be accepted.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/hid_key_events.sv
// Diffs successive keyboard reports into press/release events (breaks, modifier
// changes, makes) and queues them for a CPU/console consumer.
module hid_key_events
  import hid_key_events_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [1:0]             usb_type,
  input  logic                   usb_report,
  input  logic [7:0]             key_modifiers,
  input  logic [7:0]             key1,
  input  logic [7:0]             key2,
  input  logic [7:0]             key3,
  input  logic [7:0]             key4,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic                   ev_make,
  output logic [7:0]             ev_code,
  output logic [7:0]             ev_mods,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  input  logic                   ovf_clr
);
  keys_t      in_keys, cur_keys, prev_keys, pend_keys;
  logic [7:0] cur_mods, prev_mods, pend_mods;
  logic       pend_vld, trig, disc, start;
  scan_st_t   state, state_nx;
  logic [2:0] idx, idx_nx;
  logic       push, full, empty, drop;
  hid_ev_t    ev_in, head;

  assign in_keys = {key4, key3, key2, key1};
  assign trig  = usb_report && usb_type == USB_TYP_KBD && !key_hit(HID_ROLLOVER, in_keys, NKEYS);
  assign disc  = usb_type != USB_TYP_KBD && (prev_keys != '0 || prev_mods != '0);
  assign start = state == S_IDLE && (trig || pend_vld || disc);

  // Snapshot registers. A fresh report beats a stale pending one; a disconnect
  // scans an all-zero snapshot so every held key is released.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_keys  <= '0;
      cur_mods  <= '0;
      pend_keys <= '0;
      pend_mods <= '0;
      pend_vld  <= 1'b0;
      prev_keys <= '0;
      prev_mods <= '0;
    end else begin
      if (start) begin
        pend_vld <= 1'b0;
        if (trig) begin
          cur_keys <= in_keys;
          cur_mods <= key_modifiers;
        end else if (pend_vld) begin
          cur_keys <= pend_keys;
          cur_mods <= pend_mods;
        end else begin
          cur_keys <= '0;
          cur_mods <= '0;
        end
      end else if (trig) begin
        pend_keys <= in_keys;
        pend_mods <= key_modifiers;
        pend_vld  <= 1'b1;
      end
      if (state == S_COMMIT) begin
        prev_keys <= cur_keys;
        prev_mods <= cur_mods;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx + 3'd1;
    push     = 1'b0;
    ev_in    = '{make: 1'b0, code: 8'h00, mods: cur_mods};
    case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (start) state_nx = S_BRK;
      end
      S_BRK: begin
        ev_in.code = prev_keys[idx[1:0]];
        push = prev_keys[idx[1:0]] != '0 && !key_hit(prev_keys[idx[1:0]], cur_keys, NKEYS);
        if (idx == 3'd3) begin
          state_nx = S_MOD;
          idx_nx   = '0;
        end
      end
      S_MOD: begin
        ev_in.make = cur_mods[idx];
        ev_in.code = HID_MOD_BASE | {5'd0, idx};
        push = prev_mods[idx] != cur_mods[idx];
        if (idx == 3'd7) begin
          state_nx = S_MAK;
          idx_nx   = '0;
        end
      end
      S_MAK: begin
        ev_in.make = 1'b1;
        ev_in.code = cur_keys[idx[1:0]];
        // Duplicate slots within one report produce a single make.
        push = cur_keys[idx[1:0]] != '0 && !key_hit(cur_keys[idx[1:0]], prev_keys, NKEYS)
               && !key_hit(cur_keys[idx[1:0]], cur_keys, int'(idx));
        if (idx == 3'd3) begin
          state_nx = S_COMMIT;
          idx_nx   = '0;
        end
      end
      S_COMMIT: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  sync_fifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (ev_in),
    .pop    (ev_ready),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (ev_count),
    .drop   (drop)
  );

  always_ff @(posedge clk) begin
    if (!resetn)      overflow <= 1'b0;
    else if (ovf_clr) overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
  end

  assign ev_valid = ~empty;
  assign ev_make  = head.make;
  assign ev_code  = head.code;
  assign ev_mods  = head.mods;
endmodule

// File: tb/tb_hid_key_events.sv
// Bench for hid_key_events: directed scenarios plus random reports, checked
// against a set-level event model with a bounded queue.
module tb_hid_key_events;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] usb_type = 2'd1;
  logic       usb_report = 1'b0;
  logic [7:0] key_modifiers = '0, key1 = '0, key2 = '0, key3 = '0, key4 = '0;
  logic       ev_valid, ev_make, overflow;
  logic       ev_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] ev_code, ev_mods;
  logic [4:0] ev_count;

  always #5 clk = ~clk;

  hid_key_events #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .usb_type(usb_type), .usb_report(usb_report),
    .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_make(ev_make), .ev_code(ev_code),
    .ev_mods(ev_mods), .ev_count(ev_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: previous snapshot, event queue capped at DEPTH, sticky overflow.
  logic [31:0] m_keys = '0;
  logic [7:0]  m_mods = '0;
  logic [16:0] m_q[$];
  bit          m_ovf = 1'b0;

  function automatic bit has(input logic [31:0] set, input logic [7:0] k, input int n);
    for (int j = 0; j < n; j++) if (set[8*j +: 8] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_push(input logic [16:0] e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic m_apply(input logic [7:0] nm, input logic [31:0] nk);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k = m_keys[8*i +: 8];
      if (k != 0 && !has(nk, k, 4)) m_push({1'b0, k, nm});
    end
    for (int b = 0; b < 8; b++)
      if (m_mods[b] != nm[b]) m_push({nm[b], 8'hE0 + 8'(b), nm});
    for (int i = 0; i < 4; i++) begin
      k = nk[8*i +: 8];
      if (k != 0 && !has(m_keys, k, 4) && !has(nk, k, i)) m_push({1'b1, k, nm});
    end
    m_keys = nk;
    m_mods = nm;
  endtask

  task automatic m_report(input logic [7:0] nm, input logic [31:0] nk);
    if (!has(nk, 8'h01, 4)) m_apply(nm, nk);
  endtask

  task automatic m_disc();
    if (m_keys != 0 || m_mods != 0) m_apply(8'h00, 32'h0);
  endtask

  task automatic send(input logic [7:0] m, input logic [31:0] k, input int settle);
    usb_type = 2'd1;
    key_modifiers = m;
    {key4, key3, key2, key1} = k;
    usb_report = 1'b1;
    @(negedge clk);
    usb_report = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic clr_ovf();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [16:0] e;
    chk({tag, "_count"}, 32'(ev_count), m_q.size());
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    ev_ready = 1'b1;
    while (m_q.size() > 0) begin
      e = m_q.pop_front();
      chk({tag, "_valid"}, 32'(ev_valid), 1);
      chk({tag, "_event"}, {15'd0, ev_make, ev_code, ev_mods}, {15'd0, e});
      @(negedge clk);
    end
    ev_ready = 1'b0;
    chk({tag, "_empty"}, 32'(ev_valid), 0);
    chk({tag, "_count0"}, 32'(ev_count), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_make"},  32'(ev_make), 0);
    chk({tag, "_code"},  32'(ev_code), 0);
    chk({tag, "_mods"},  32'(ev_mods), 0);
    chk({tag, "_count"}, 32'(ev_count), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
  endtask

  function automatic logic [7:0] rkey();
    int r = $urandom_range(0, 9);
    return (r < 4) ? 8'h00 : 8'h04 + 8'(r - 4);
  endfunction

  initial begin
    int lat;
    logic [31:0] k;
    logic [7:0]  m;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Press A, including strobe-to-ev_valid latency.
    send(8'h00, 32'h04, 0);
    lat = 0;
    while (!ev_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("press_latency", lat, 13);
    repeat (8) @(negedge clk);
    m_report(8'h00, 32'h04);
    chk("press_count", 32'(ev_count), 1);
    chk("press_head", {ev_make, ev_code, ev_mods}, {1'b1, 8'h04, 8'h00});
    drain("press");

    // Release plus left-shift.
    send(8'h02, 32'h0, 20);
    m_report(8'h02, 32'h0);
    chk("relmod_head", {ev_make, ev_code, ev_mods}, {1'b0, 8'h04, 8'h02});
    drain("relmod");

    // Rollover report is ignored; next report diffs against the old snapshot.
    send(8'h00, 32'h04, 20);
    m_report(8'h00, 32'h04);
    drain("pre_roll");
    send(8'h00, 32'h01010101, 20);
    m_report(8'h00, 32'h01010101);
    chk("roll_none", 32'(ev_count), 0);
    send(8'h00, 32'h05, 20);
    m_report(8'h00, 32'h05);
    drain("post_roll");

    // Reports during a scan: pending is one deep, newest wins.
    send(8'h10, 32'h06, 2);
    send(8'h00, 32'h07, 1);
    send(8'h00, 32'h0608, 40);
    m_report(8'h10, 32'h06);
    m_report(8'h00, 32'h0608);
    drain("pending");

    // Overflow with consumer stalled, then clear.
    send(8'h00, 32'h07060504, 20);
    m_report(8'h00, 32'h07060504);
    send(8'hFF, 32'h0, 20);
    m_report(8'hFF, 32'h0);
    send(8'h00, 32'h0B0A0908, 20);
    m_report(8'h00, 32'h0B0A0908);
    chk("ovf_count", 32'(ev_count), 16);
    chk("ovf_set", 32'(overflow), 1);
    clr_ovf();
    chk("ovf_clr", 32'(overflow), 0);
    drain("ovf");

    // Disconnect releases held keys.
    send(8'h00, 32'h0504, 20);
    m_report(8'h00, 32'h0504);
    drain("pre_disc");
    usb_type = 2'd0;
    repeat (17) @(negedge clk);
    chk("disc_count", 32'(ev_count), 2);
    m_disc();
    drain("disc");
    usb_type = 2'd1;

    // Reset during BRK2 with events queued.
    send(8'h00, 32'h04, 20);
    send(8'h00, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre", 32'(ev_count), 2);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    resetn = 1'b1;
    m_q.delete();
    m_keys = '0;
    m_mods = '0;
    m_ovf = 1'b0;
    send(8'h00, 32'h04, 20);
    m_report(8'h00, 32'h04);
    drain("post_rst");

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          usb_type = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'(2 + $urandom_range(0, 1));
          usb_report = 1'($urandom_range(0, 1));
          @(negedge clk);
          usb_report = 1'b0;
          repeat (20) @(negedge clk);
          m_disc();
          usb_type = 2'd1;
        end
        1: begin
          k = {rkey(), rkey(), rkey(), rkey()};
          k[8*$urandom_range(0, 3) +: 8] = 8'h01;
          send(8'($urandom), k, 20);
          m_report(key_modifiers, k);
        end
        default: begin
          k = {rkey(), rkey(), rkey(), rkey()};
          m = 8'($urandom) & 8'($urandom);
          send(m, k, 20);
          m_report(m, k);
        end
      endcase
      if ($urandom_range(0, 7) == 0) clr_ovf();
      if ($urandom_range(0, 2) == 0) drain("rand");
    end
    drain("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
